pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 114 +++++++++++
 tb/tb_pipe_skid_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int                CLR_DATA    = 0,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holding valid must keep its payload stable until then.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [DATA_W-1:0]        r_main;
    logic [DATA_W-1:0]        r_skid;
    logic [DATA_W-1:0]        w_main_nxt;
    logic [DATA_W-1:0]        w_skid_nxt;
    logic                     r_in_ready;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;
    logic                     w_acc;
    logic                     w_pop;
    logic                     w_stall;

    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign in_ready  = r_in_ready;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

    assign w_acc   = in_valid & r_in_ready;
    assign w_pop   = out_valid & out_ready;
    assign w_stall = out_valid & ~out_ready;

    always_comb begin
        w_next_state = r_state;
        w_main_nxt   = r_main;
        w_skid_nxt   = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_next_state = S_ONE;
                    w_main_nxt   = in_data;
                end
            end
            S_ONE: begin
                if (w_acc && w_pop) begin
                    w_main_nxt = in_data;
                end else if (w_acc) begin
                    w_next_state = S_FULL;
                    w_skid_nxt   = in_data;
                end else if (w_pop) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only a pop can move the state.
                if (w_pop) begin
                    w_next_state = S_ONE;
                    w_main_nxt   = r_skid;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase

        // Flush wins over the handshake; a payload accepted this cycle is dropped.
        if (clr) begin
            w_next_state = S_EMPTY;
            if (CLR_DATA != 0) begin
                w_main_nxt = RESET_VAL;
                w_skid_nxt = RESET_VAL;
            end else begin
                w_main_nxt = r_main;
                w_skid_nxt = r_skid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_next_state != S_FULL);
            if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: two instances share stimulus, one with default
// parameters and one with CLR_DATA=1, non-zero RESET_VAL and a 4-bit stall counter.
module tb_pipe_skid_reg;

    localparam int          DW    = 32;
    localparam logic [31:0] B_RST = 32'hDEAD_BEEF;

    logic          clk;
    logic          reset;
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;

    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;
    logic [3:0]    b_stall;

    int n_cmp;
    int n_bad;

    pipe_skid_reg #(.DATA_W(DW), .RESET_VAL('0), .CLR_DATA(0), .STALL_CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(B_RST), .CLR_DATA(1), .STALL_CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %0b want 1", a_in_ready); end
        n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL rst_occ got %0d want 0", a_occ); end
        n_cmp++; if (a_stall !== 16'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", a_stall); end
        n_cmp++; if (a_out_data !== 32'h0) begin n_bad++; $display("FAIL rst_data_a got %h want 0", a_out_data); end
        n_cmp++; if (b_out_data !== B_RST) begin n_bad++; $display("FAIL rst_data_b got %h want %h", b_out_data, B_RST); end
    endtask

    task automatic test_pass_through();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            step();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== i) begin n_bad++; $display("FAIL pass_data[%0d] got v=%0b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, i); end
            n_cmp++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL pass_occ[%0d] got occ=%0d rdy=%0b want occ=1 rdy=1", i, a_occ, a_in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_empty got occ=%0d v=%0b want 0 0", a_occ, a_out_valid); end
        n_cmp++; if (a_stall !== 16'd0) begin n_bad++; $display("FAIL pass_stall got %0d want 0", a_stall); end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        n_cmp++; if (a_occ !== 2'd1 || a_out_data !== 32'hA || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_one got occ=%0d d=%h rdy=%0b want 1 a 1", a_occ, a_out_data, a_in_ready); end
        in_data = 32'hB;
        step();
        n_cmp++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 32'hA) begin n_bad++; $display("FAIL fill_full got occ=%0d rdy=%0b d=%h want 2 0 a", a_occ, a_in_ready, a_out_data); end
        n_cmp++; if (a_stall !== 16'd1) begin n_bad++; $display("FAIL fill_stall1 got %0d want 1", a_stall); end
        in_data = 32'hC;
        step();
        step();
        n_cmp++; if (a_occ !== 2'd2 || a_out_data !== 32'hA || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL fill_hold got occ=%0d d=%h v=%0b want 2 a 1", a_occ, a_out_data, a_out_valid); end
        n_cmp++; if (a_stall !== 16'd3 || b_stall !== 4'd3) begin n_bad++; $display("FAIL fill_stall3 got a=%0d b=%0d want 3 3", a_stall, b_stall); end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        step();
        n_cmp++; if (a_out_data !== 32'hB || a_out_valid !== 1'b1 || a_occ !== 2'd1) begin n_bad++; $display("FAIL drain_b got d=%h v=%0b occ=%0d want b 1 1", a_out_data, a_out_valid, a_occ); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got %0b want 1", a_in_ready); end
        step();
        n_cmp++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got occ=%0d v=%0b want 0 0 (0xC must not be taken)", a_occ, a_out_valid); end
        n_cmp++; if (a_stall !== 16'd3) begin n_bad++; $display("FAIL drain_stall got %0d want 3", a_stall); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        n_cmp++; if (a_occ !== 2'd2 || b_occ !== 2'd2) begin n_bad++; $display("FAIL flush_pre got a=%0d b=%0d want 2 2", a_occ, b_occ); end
        clr     = 1'b1;
        in_data = 32'hD;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_a got occ=%0d v=%0b rdy=%0b want 0 0 1", a_occ, a_out_valid, a_in_ready); end
        n_cmp++; if (b_occ !== 2'd0 || b_out_data !== B_RST) begin n_bad++; $display("FAIL flush_b got occ=%0d d=%h want 0 %h", b_occ, b_out_data, B_RST); end
        n_cmp++; if (a_out_data !== 32'h11) begin n_bad++; $display("FAIL flush_keep got %h want 11", a_out_data); end
        n_cmp++; if (a_stall !== 16'd5 || b_stall !== 4'd5) begin n_bad++; $display("FAIL flush_stall got a=%0d b=%0d want 5 5", a_stall, b_stall); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_d got a=%0b b=%0b want 0 0", a_out_valid, b_out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (b_stall !== 4'd15) begin n_bad++; $display("FAIL sat_b got %0d want 15", b_stall); end
        n_cmp++; if (a_stall !== 16'd25) begin n_bad++; $display("FAIL sat_a got %0d want 25", a_stall); end
        step();
        n_cmp++; if (b_stall !== 4'd15 || a_stall !== 16'd26) begin n_bad++; $display("FAIL sat_hold got b=%0d a=%0d want 15 26", b_stall, a_stall); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_data  = 32'h88;
        step();
        in_valid = 1'b0;
        n_cmp++; if (a_occ !== 2'd2 || a_out_data !== 32'h77) begin n_bad++; $display("FAIL ar_full got occ=%0d d=%h want 2 77", a_occ, a_out_data); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_state got occ=%0d v=%0b rdy=%0b want 0 0 1", a_occ, a_out_valid, a_in_ready); end
        n_cmp++; if (a_stall !== 16'd0 || b_stall !== 4'd0) begin n_bad++; $display("FAIL ar_stall got a=%0d b=%0d want 0 0", a_stall, b_stall); end
        n_cmp++; if (a_out_data !== 32'h0 || b_out_data !== B_RST) begin n_bad++; $display("FAIL ar_data got a=%h b=%h want 0 %h", a_out_data, b_out_data, B_RST); end
        #1 reset = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h99;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h99 || a_occ !== 2'd1) begin n_bad++; $display("FAIL ar_push got v=%0b d=%h occ=%0d want 1 99 1", a_out_valid, a_out_data, a_occ); end
        step();
        n_cmp++; if (a_occ !== 2'd0) begin n_bad++; $display("FAIL ar_drain got occ=%0d want 0", a_occ); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        test_reset();
        test_pass_through();
        test_stall_fill();
        test_drain();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
